safety_monitor_nch: RTL and testbench
=====================================

Name: safety_monitor_nch

Overview:
- Parametrised successor to the fixed four-instance per-axis safety check.
- A single time-multiplexed comparator scans NUM_CHAN current-feedback/command pairs round-robin.
- Filters violations through per-channel persistence counters and latches per-channel amp-disable bits.
- Exposes a status/clear register on the host register bus, next to the board register block.

Parameters:
- NUM_CHAN, 4, number of channels scanned (1..16).
- DATA_W, 16, ADC/DAC word width, offset-binary coding.
- LIMIT, 4, consecutive-violation count that trips a channel (1..255).
- MARGIN, 16'h0100, additive threshold margin in magnitude LSBs.
- LEAKY, 0, counter mode: 0 = clear counter on a good sample; 1 = decrement by 1 (floor 0).
- ADDR, 16'h000A, register address for status read and clear write.

Ports:
- sysclk  in  1  system clock (49.152 MHz).
- reset  in  1  asynchronous, active-low reset.
- cur_fb  in  NUM_CHAN*DATA_W  packed feedback; channel k in [k*DATA_W +: DATA_W].
- cur_cmd  in  NUM_CHAN*DATA_W  packed DAC command, same packing.
- reg_wen  in  1  register write strobe (one sysclk).
- reg_waddr  in  16  write address.
- reg_wdata  in  32  write data.
- reg_raddr  in  16  read address.
- reg_rdata  out  32  read data; combinational; 0 when reg_raddr != ADDR.
- amp_disable  out  NUM_CHAN  latched per-channel disable.
- trip_any  out  1  OR of amp_disable.

Behaviour:
- Scan pointer idx runs 0..NUM_CHAN-1, advances every cycle, wraps to 0. NUM_CHAN=1 holds at 0.
- Stage 1 (registered): capture channel idx.
  - Compute mag(x) = x[MSB] ? x - 2^(DATA_W-1) : 2^(DATA_W-1) - x, in DATA_W bits. 0x0000 -> 0x8000.
  - Compute thr = 2*mag(cmd) + MARGIN in DATA_W+2 bits; no overflow or wrap.
  - Set v1 = 1.
- Stage 2 (registered): when v1 = 1, viol = mag(fb) > thr (strict).
  - viol: counter[ch] increments, saturating at LIMIT.
  - Good sample, LEAKY=0: counter[ch] cleared.
  - Good sample, LEAKY=1: counter[ch] decremented by 1, floor 0.
- Trip: amp_disable[ch] sets on the cycle the counter update reaches LIMIT. It stays set until cleared or reset.
- Latency: a sustained violation trips after LIMIT scans of that channel. Worst case from input change to amp_disable is NUM_CHAN*LIMIT + 2 cycles.
- First-fault capture:
  - When first_valid = 0 and a channel trips, first_idx <= ch and first_valid <= 1.
  - first_valid clears when all amp_disable bits become 0 via a clear.
- Clear: reg_wen && reg_waddr == ADDR. For every k with reg_wdata[k] = 1, clear amp_disable[k] and counter[k] on the next edge.
- Simultaneous clear and trip on the same channel, same edge: trip wins; the bit stays set and the counter stays at LIMIT (safety priority).
- A clear while the violation persists re-trips after LIMIT further scans.
- reg_rdata layout: [31] first_valid, [30:28] 0, [27:24] first_idx, [23:16] 0, [15:0] amp_disable zero-extended.
- Reset (asynchronous, reset = 0) forces all of the following regardless of phase, including mid-count:
  - idx = 0, v1 = 0;
  - all counters = 0;
  - amp_disable = 0, trip_any = 0;
  - first_valid = 0, first_idx = 0.
- Normal operation resumes on the first edge after release.

Test Plan:
- NUM_CHAN=4, LIMIT=4, MARGIN=0x100. All fb = cmd = 0x8000 for 1000 cycles -> amp_disable = 0, reg_rdata at ADDR = 0x00000000.
- ch2 cmd = 0x9000 (mag 0x1000), fb = 0xA101 (mag 0x2101 > thr 0x2100), sustained -> amp_disable = 4'b0100 within 18 cycles, trip_any = 1.
- ch2 with fb = 0xA100 (equal to threshold) -> never trips. ch0 with fb = 0x0000, cmd = 0x8000 (mag 0x8000 > 0x100) -> trips.
- LEAKY=0, pattern 3 bad / 1 good samples on ch1 -> no trip. Same pattern with LEAKY=1 -> counter nets +2 per 4 samples and trips.
- Trip ch3, then ch1 -> reg_rdata = 0x8300000A.
  - Write 0x2 with ch1 violation removed -> 0x83000008.
  - Write 0x8 -> 0x00000000.
  - Clear ch1 on the same edge as its trip -> bit remains 1.
- Drop reset for one cycle with ch2 counter at 3 -> all outputs 0 immediately. After release, a sustained violation needs a full 4 scans to trip.

Source files
------------

// File: rtl/safety_monitor_nch.sv
// rtl/safety_monitor_nch.sv - time-multiplexed current-limit monitor with per-channel persistence filters
// One comparator scans all channels round-robin; trips latch amp-disable bits cleared over the register bus.
module safety_monitor_nch #(
    parameter int unsigned NUM_CHAN = 4,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LIMIT    = 4,
    parameter int unsigned MARGIN   = 16'h0100,
    parameter int unsigned LEAKY    = 0,
    parameter int unsigned ADDR     = 16'h000A
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic [NUM_CHAN*DATA_W-1:0]   cur_fb,
    input  logic [NUM_CHAN*DATA_W-1:0]   cur_cmd,
    input  logic                         reg_wen,
    input  logic [15:0]                  reg_waddr,
    input  logic [31:0]                  reg_wdata,
    input  logic [15:0]                  reg_raddr,
    output logic [31:0]                  reg_rdata,
    output logic [NUM_CHAN-1:0]          amp_disable,
    output logic                         trip_any
);

    localparam int unsigned IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned THR_W = DATA_W + 2;
    localparam logic [CNT_W-1:0]  LIM  = CNT_W'(LIMIT);
    localparam logic [DATA_W-1:0] HALF = {1'b1, {(DATA_W-1){1'b0}}};

    // Offset-binary to magnitude; full-scale negative (all zeros) maps to HALF.
    function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? (x - HALF) : (HALF - x);
    endfunction

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              v1_q, v1_d;
    logic [IDX_W-1:0]  ch1_q, ch1_d;
    logic [DATA_W-1:0] fbmag_q, fbmag_d;
    logic [THR_W-1:0]  thr_q, thr_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CHAN];
    logic [CNT_W-1:0]  cnt_d [NUM_CHAN];
    logic [NUM_CHAN-1:0] amp_q, amp_d;
    logic              first_valid_q, first_valid_d;
    logic [3:0]        first_idx_q, first_idx_d;

    logic [DATA_W-1:0] fb_sel, cmd_sel;
    logic [CNT_W-1:0]  cnt_cur, cnt_upd;
    logic              viol, trip, clr_hit;
    logic [NUM_CHAN-1:0] clr_mask;

    wire unused_wdata = &{1'b0, reg_wdata[31:NUM_CHAN]};

    always_comb begin
        fb_sel  = '0;
        cmd_sel = '0;
        for (int k = 0; k < int'(NUM_CHAN); k++) begin
            if (idx_q == IDX_W'(k)) begin
                fb_sel  = cur_fb[k*DATA_W +: DATA_W];
                cmd_sel = cur_cmd[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        idx_d   = (idx_q == IDX_W'(NUM_CHAN - 1)) ? '0 : idx_q + 1'b1;
        v1_d    = 1'b1;
        ch1_d   = idx_q;
        fbmag_d = mag_f(fb_sel);
        thr_d   = {1'b0, mag_f(cmd_sel), 1'b0} + THR_W'(MARGIN);
    end

    // Stage 2: persistence counter update for the channel captured last cycle.
    always_comb begin
        viol    = v1_q && ({2'b00, fbmag_q} > thr_q);
        cnt_cur = '0;
        for (int k = 0; k < int'(NUM_CHAN); k++) begin
            if (ch1_q == IDX_W'(k)) cnt_cur = cnt_q[k];
        end
        if (viol) begin
            cnt_upd = (cnt_cur == LIM) ? LIM : cnt_cur + 1'b1;
        end else if (LEAKY != 0) begin
            cnt_upd = (cnt_cur == '0) ? '0 : cnt_cur - 1'b1;
        end else begin
            cnt_upd = '0;
        end
        trip = viol && (cnt_upd == LIM);
    end

    always_comb begin
        clr_hit  = reg_wen && (reg_waddr == 16'(ADDR));
        clr_mask = clr_hit ? reg_wdata[NUM_CHAN-1:0] : '0;
        amp_d    = amp_q;
        for (int k = 0; k < int'(NUM_CHAN); k++) begin
            cnt_d[k] = cnt_q[k];
            if (v1_q && (ch1_q == IDX_W'(k))) cnt_d[k] = cnt_upd;
            // A trip outranks a clear landing on the same edge.
            if (trip && (ch1_q == IDX_W'(k))) begin
                amp_d[k] = 1'b1;
            end else if (clr_mask[k]) begin
                amp_d[k] = 1'b0;
                cnt_d[k] = '0;
            end
        end

        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        if (!first_valid_q && trip) begin
            first_valid_d = 1'b1;
            first_idx_d   = 4'(ch1_q);
        end else if (clr_hit && (amp_d == '0)) begin
            first_valid_d = 1'b0;
            first_idx_d   = '0;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            idx_q         <= '0;
            v1_q          <= 1'b0;
            ch1_q         <= '0;
            fbmag_q       <= '0;
            thr_q         <= '0;
            amp_q         <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            for (int k = 0; k < int'(NUM_CHAN); k++) cnt_q[k] <= '0;
        end else begin
            idx_q         <= idx_d;
            v1_q          <= v1_d;
            ch1_q         <= ch1_d;
            fbmag_q       <= fbmag_d;
            thr_q         <= thr_d;
            amp_q         <= amp_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            for (int k = 0; k < int'(NUM_CHAN); k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign amp_disable = amp_q;
    assign trip_any    = |amp_q;
    assign reg_rdata   = (reg_raddr == 16'(ADDR))
                       ? {first_valid_q, 3'b000, first_idx_q, 8'h00, 16'(amp_q)}
                       : 32'h0;

endmodule

// File: tb/tb_safety_monitor_nch.sv
// tb/tb_safety_monitor_nch.sv - directed-vector bench for safety_monitor_nch
module tb_safety_monitor_nch;

    localparam logic [15:0] A = 16'h000A;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [63:0] cur_fb, cur_cmd;
    logic        reg_wen;
    logic [15:0] reg_waddr, reg_raddr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata, reg_rdata_lk;
    logic [3:0]  amp_disable, amp_lk;
    logic        trip_any, trip_any_lk;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sysclk = ~sysclk;

    safety_monitor_nch #(.NUM_CHAN(4), .DATA_W(16), .LIMIT(4), .MARGIN(16'h0100),
                         .LEAKY(0), .ADDR(16'h000A)) dut (
        .sysclk(sysclk), .reset(reset), .cur_fb(cur_fb), .cur_cmd(cur_cmd),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .amp_disable(amp_disable), .trip_any(trip_any)
    );

    safety_monitor_nch #(.NUM_CHAN(4), .DATA_W(16), .LIMIT(4), .MARGIN(16'h0100),
                         .LEAKY(1), .ADDR(16'h000A)) dut_lk (
        .sysclk(sysclk), .reset(reset), .cur_fb(cur_fb), .cur_cmd(cur_cmd),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata_lk),
        .amp_disable(amp_lk), .trip_any(trip_any_lk)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [15:0] fb, input logic [15:0] cmd);
        cur_fb[k*16 +: 16]  = fb;
        cur_cmd[k*16 +: 16] = cmd;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [31:0] d);
        reg_wen   = 1'b1;
        reg_waddr = a;
        reg_wdata = d;
        @(negedge sysclk);
        reg_wen   = 1'b0;
        reg_wdata = 32'h0;
    endtask

    // Returns on the first falling edge after amp_disable[ch] rises.
    task automatic wait_trip(input int ch, input string tag);
        int n = 0;
        while (!amp_disable[ch] && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        check(tag, 32'(amp_disable[ch]), 32'h1);
    endtask

    initial begin
        reset     = 1'b0;
        reg_wen   = 1'b0;
        reg_waddr = 16'h0;
        reg_wdata = 32'h0;
        reg_raddr = A;
        for (int k = 0; k < 4; k++) set_ch(k, 16'h8000, 16'h8000);
        cycles(3);
        check("rst_amp", 32'(amp_disable), 32'h0);
        check("rst_trip_any", 32'(trip_any), 32'h0);
        check("rst_rdata", reg_rdata, 32'h0);

        reset = 1'b1;
        cycles(1000);
        check("idle_amp", 32'(amp_disable), 32'h0);
        check("idle_rdata", reg_rdata, 32'h0);

        set_ch(2, 16'hA101, 16'h9000);
        cycles(18);
        check("ch2_amp", 32'(amp_disable), 32'h4);
        check("ch2_trip_any", 32'(trip_any), 32'h1);
        check("ch2_rdata", reg_rdata, 32'h82000004);
        reg_write(16'h000B, 32'h4);
        check("wrong_addr_keep", 32'(amp_disable), 32'h4);
        reg_raddr = 16'h0000;
        #1;
        check("raddr_miss", reg_rdata, 32'h0);
        reg_raddr = A;
        set_ch(2, 16'h9000, 16'h9000);
        cycles(8);
        reg_write(A, 32'h4);
        check("ch2_clear", reg_rdata, 32'h0);

        set_ch(2, 16'hA100, 16'h9000);
        cycles(100);
        check("equal_thr_no_trip", 32'(amp_disable), 32'h0);
        set_ch(2, 16'h8000, 16'h8000);

        set_ch(0, 16'h0000, 16'h8000);
        cycles(18);
        check("ch0_fullscale_amp", 32'(amp_disable), 32'h1);
        set_ch(0, 16'h8000, 16'h8000);
        cycles(8);
        reg_write(A, 32'h1);
        check("ch0_clear", 32'(amp_disable), 32'h0);
        check("ch0_clear_lk", 32'(amp_lk), 32'h0);

        // 3 bad / 1 good on ch1; each value held for one full scan period.
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < 4; s++) begin
                set_ch(1, (s < 3) ? 16'h0000 : 16'h8000, 16'h8000);
                cycles(4);
            end
        end
        cycles(4);
        check("pattern_leaky0_no_trip", 32'(amp_disable), 32'h0);
        check("pattern_leaky1_trip", 32'(amp_lk), 32'h2);
        cycles(8);
        reg_write(A, 32'h2);

        set_ch(3, 16'h0000, 16'h8000);
        cycles(18);
        check("ch3_amp", 32'(amp_disable), 32'h8);
        set_ch(1, 16'h0000, 16'h8000);
        cycles(18);
        check("two_trip_rdata", reg_rdata, 32'h8300000A);
        set_ch(1, 16'h8000, 16'h8000);
        cycles(8);
        reg_write(A, 32'h2);
        check("clear_ch1_rdata", reg_rdata, 32'h83000008);
        set_ch(3, 16'h8000, 16'h8000);
        cycles(8);
        reg_write(A, 32'h8);
        check("clear_all_rdata", reg_rdata, 32'h0);
        cycles(20);
        check("stay_clear_rdata", reg_rdata, 32'h0);

        // Clear right after a trip, then land a second clear on the re-trip edge.
        set_ch(1, 16'h0000, 16'h8000);
        wait_trip(1, "ch1_trip");
        reg_write(A, 32'h2);
        check("ch1_cleared", 32'(amp_disable), 32'h0);
        cycles(14);
        check("ch1_no_early_retrip", 32'(amp_disable), 32'h0);
        reg_write(A, 32'h2);
        check("clr_vs_trip_amp", 32'(amp_disable), 32'h2);
        check("clr_vs_trip_rdata", reg_rdata, 32'h81000002);

        // Bring ch2 counter to 3, then pulse reset.
        set_ch(2, 16'h0000, 16'h8000);
        wait_trip(2, "ch2_trip_again");
        check("ch2_ch1_rdata", reg_rdata, 32'h81000006);
        reg_write(A, 32'h4);
        check("ch2_recleared", 32'(amp_disable), 32'h2);
        cycles(11);
        check("ch2_cnt3_no_trip", 32'(amp_disable), 32'h2);
        reset = 1'b0;
        #1;
        check("midrst_amp", 32'(amp_disable), 32'h0);
        check("midrst_trip_any", 32'(trip_any), 32'h0);
        check("midrst_rdata", reg_rdata, 32'h0);
        @(negedge sysclk);
        reset = 1'b1;
        cycles(15);
        check("post_rst_15", 32'(amp_disable), 32'h2);
        cycles(1);
        check("post_rst_16", 32'(amp_disable), 32'h6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
